// File: rtl/miner_job_dispatcher.sv
// miner_job_dispatcher
//  Shifts in one mining job (MID_WORDS midstate words, then HEAD_WORDS header words).
//  Loads it into NUM_ENG external SHA engines, each with a disjoint nonce base.
//  Buffers engine solutions and hands them to the host one at a time on a
//  claim/response handshake.
//
//  Ports
//   clk, n_rst                      clock, async active-low reset
//   start_found                     new job; aborts everything in flight
//   shift_in_enable, in_data        host job word stream
//   mid_data, head_data             job registers; first word shifted in is the MS word
//   eng_load, eng_solve             engine control
//   eng_nonce_base                  per-engine start nonce
//   eng_found, eng_nonce, eng_done  engine status
//   sol_claim, out_data, out_eng_id claim presented to host
//   sol_response                    host accepts the current claim
//   exhausted                       every range searched, nothing pending
//   sol_count                       accepted-claim count
//
//  Build option: define SOL_COUNT_EN to build the saturating accepted-claim counter;
//  otherwise sol_count is tied to 0.
module miner_job_dispatcher #(
    parameter int unsigned NUM_ENG    = 4,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned MID_WORDS  = 8,
    parameter int unsigned HEAD_WORDS = 16,
    parameter int unsigned NONCE_W    = 32
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            start_found,
    input  logic                            shift_in_enable,
    input  logic [WORD_W-1:0]               in_data,
    output logic [MID_WORDS*WORD_W-1:0]     mid_data,
    output logic [HEAD_WORDS*WORD_W-1:0]    head_data,
    output logic                            eng_load,
    output logic                            eng_solve,
    output logic [NUM_ENG*NONCE_W-1:0]      eng_nonce_base,
    input  logic [NUM_ENG-1:0]              eng_found,
    input  logic [NUM_ENG*NONCE_W-1:0]      eng_nonce,
    input  logic [NUM_ENG-1:0]              eng_done,
    output logic                            sol_claim,
    output logic [NONCE_W-1:0]              out_data,
    output logic [$clog2(NUM_ENG):0]        out_eng_id,
    input  logic                            sol_response,
    output logic                            exhausted,
    output logic [15:0]                     sol_count
);

    localparam int unsigned ENG_W  = $clog2(NUM_ENG);
    localparam int unsigned ID_W   = ENG_W + 1;
    localparam int unsigned MID_W  = MID_WORDS * WORD_W;
    localparam int unsigned HEAD_W = HEAD_WORDS * WORD_W;
    localparam int unsigned CNT_W  = $clog2(MID_WORDS + HEAD_WORDS + 1);

    typedef enum logic [2:0] {
        StIdle, StLoadMid, StLoadHead, StDispatch, StSolve, StClaim, StExhaust
    } state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [MID_W-1:0]           mid_q, mid_d;
    logic [HEAD_W-1:0]          head_q, head_d;
    logic [NUM_ENG-1:0]         pend_q, pend_d;
    logic [NONCE_W-1:0]         pnonce_q [NUM_ENG];
    logic [NONCE_W-1:0]         pnonce_d [NUM_ENG];
    logic [NONCE_W-1:0]         out_data_q, out_data_d;
    logic [ID_W-1:0]            out_id_q, out_id_d;
    logic [NUM_ENG*NONCE_W-1:0] base_q, base_d;
    logic                       found_en, accept, load_claim;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mid_d      = mid_q;
        head_d     = head_q;
        pend_d     = pend_q;
        pnonce_d   = pnonce_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        base_d     = base_q;
        eng_load   = 1'b0;
        eng_solve  = 1'b0;
        sol_claim  = 1'b0;
        exhausted  = 1'b0;
        load_claim = 1'b0;
        found_en   = (state_q == StSolve) || (state_q == StClaim);
        accept     = (state_q == StClaim) && sol_response;

        // Clear the accepted entry before capturing finds, so a find on the
        // engine being accepted re-arms it with the new nonce.
        for (int i = 0; i < NUM_ENG; i++) begin
            if (accept && (out_id_q == ID_W'(i))) pend_d[i] = 1'b0;
        end
        for (int i = 0; i < NUM_ENG; i++) begin
            if (found_en && eng_found[i] && !pend_d[i]) begin
                pend_d[i]   = 1'b1;
                pnonce_d[i] = eng_nonce[i*NONCE_W +: NONCE_W];
            end
        end

        case (state_q)
            StIdle: ;
            StLoadMid: begin
                if (shift_in_enable) begin
                    mid_d = {mid_q[MID_W-WORD_W-1:0], in_data};
                    if (cnt_q == CNT_W'(MID_WORDS - 1)) begin
                        cnt_d   = '0;
                        state_d = StLoadHead;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StLoadHead: begin
                if (shift_in_enable) begin
                    head_d = {head_q[HEAD_W-WORD_W-1:0], in_data};
                    if (cnt_q == CNT_W'(HEAD_WORDS - 1)) begin
                        cnt_d   = '0;
                        state_d = StDispatch;
                        for (int i = 0; i < NUM_ENG; i++) begin
                            base_d[i*NONCE_W +: NONCE_W] = NONCE_W'(i) << (NONCE_W - ENG_W);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StDispatch: begin
                eng_load = 1'b1;
                state_d  = StSolve;
            end
            StSolve: begin
                eng_solve = 1'b1;
                // Finds arriving this cycle count, giving one-cycle claim latency.
                if (|pend_d) begin
                    state_d    = StClaim;
                    load_claim = 1'b1;
                end else if (&eng_done) begin
                    state_d = StExhaust;
                end
            end
            StClaim: begin
                sol_claim = 1'b1;
                if (sol_response) begin
                    if (|pend_d) load_claim = 1'b1;
                    else         state_d    = StSolve;
                end
            end
            StExhaust: exhausted = 1'b1;
            default:   state_d   = StIdle;
        endcase

        // Latch the lowest-index pending entry so the claim stays stable.
        if (load_claim) begin
            for (int i = NUM_ENG - 1; i >= 0; i--) begin
                if (pend_d[i]) begin
                    out_data_d = pnonce_d[i];
                    out_id_d   = ID_W'(i);
                end
            end
        end

        if (start_found) begin
            state_d = StLoadMid;
            cnt_d   = '0;
            mid_d   = '0;
            head_d  = '0;
            pend_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mid_q      <= '0;
            head_q     <= '0;
            pend_q     <= '0;
            out_data_q <= '0;
            out_id_q   <= '0;
            base_q     <= '0;
            for (int i = 0; i < NUM_ENG; i++) pnonce_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mid_q      <= mid_d;
            head_q     <= head_d;
            pend_q     <= pend_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            base_q     <= base_d;
            for (int i = 0; i < NUM_ENG; i++) pnonce_q[i] <= pnonce_d[i];
        end
    end

    assign mid_data       = mid_q;
    assign head_data      = head_q;
    assign eng_nonce_base = base_q;
    assign out_data       = out_data_q;
    assign out_eng_id     = out_id_q;

`ifdef SOL_COUNT_EN
    logic [15:0] sol_cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sol_cnt_q <= '0;
        end else if (start_found) begin
            sol_cnt_q <= '0;
        end else if (sol_claim && sol_response && (sol_cnt_q != 16'hFFFF)) begin
            sol_cnt_q <= sol_cnt_q + 16'd1;
        end
    end

    assign sol_count = sol_cnt_q;
`else
    assign sol_count = '0;
`endif

endmodule
